// File: rtl/exception_sequencer.sv
// Exception/ERET sequencer: drains outstanding memory traffic, flushes the pipe,
// commits CP0 state for exceptions and hands the redirect target to fetch.
module exception_sequencer #(
    parameter logic [7:0] DRAIN_TIMEOUT = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exp_detect,
    input  logic        exp_eret,
    input  logic [31:0] exp_pc_address,
    input  logic        mem_outstanding,
    input  logic        redirect_ready,
    output logic        stall_pipe,
    output logic        flush_pipe,
    output logic        cp0_commit,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        drain_timeout,
    output logic [15:0] exp_count
);

    localparam int unsigned PC_W    = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DRAIN_W = 8;

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_TIMEOUT - DRAIN_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 eret_q;
    logic                 eret_d;
    logic [DRAIN_W-1:0]   drain_cnt_q;
    logic [DRAIN_W-1:0]   drain_cnt_d;
    logic                 capture;
    logic                 timeout_set;
    logic                 count_inc;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            eret_q         <= 1'b0;
            drain_cnt_q    <= '0;
            redirect_pc    <= '0;
            drain_timeout  <= 1'b0;
            exp_count      <= '0;
            flush_pipe     <= 1'b0;
            cp0_commit     <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            eret_q         <= eret_d;
            drain_cnt_q    <= drain_cnt_d;
            flush_pipe     <= (state_d == FLUSH);
            cp0_commit     <= (state_d == FLUSH) && !eret_d;
            redirect_valid <= (state_d == REDIRECT);
            if (capture) begin
                redirect_pc <= exp_pc_address;
            end
            if (timeout_set) begin
                drain_timeout <= 1'b1;
            end
            if (count_inc && (exp_count != CNT_MAX)) begin
                exp_count <= exp_count + CNT_W'(1);
            end
        end
    end

    // Next-state logic; detect inputs only matter in IDLE, ready only in REDIRECT
    always_comb begin
        state_d     = state_q;
        eret_d      = eret_q;
        drain_cnt_d = drain_cnt_q;
        capture     = 1'b0;
        timeout_set = 1'b0;
        count_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (exp_detect) begin
                    capture     = 1'b1;
                    eret_d      = exp_eret;
                    drain_cnt_d = '0;
                    state_d     = mem_outstanding ? DRAIN : FLUSH;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                if (!mem_outstanding || (drain_cnt_q == DRAIN_LAST)) begin
                    state_d     = FLUSH;
                    timeout_set = mem_outstanding;
                end
            end
            FLUSH: begin
                state_d = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d   = IDLE;
                    count_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held so a stray detect cannot freeze the pipe
    assign stall_pipe = rst && ((state_q != IDLE) || exp_detect);

    logic unused_pc_w;
    assign unused_pc_w = (PC_W == 32);

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: redirect targets and commit flags are
// queued when a request is issued and checked when fetch accepts the redirect.
module tb_exception_sequencer;

    logic        clk;
    logic        rst;
    logic        exp_detect;
    logic        exp_eret;
    logic [31:0] exp_pc_address;
    logic        mem_outstanding;
    logic        redirect_ready;
    logic        stall_pipe;
    logic        flush_pipe;
    logic        cp0_commit;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        drain_timeout;
    logic [15:0] exp_count;

    typedef struct packed {
        logic [31:0] pc;
        logic        commit;
    } exp_item_t;

    exp_item_t   sb[$];
    int          tests;
    int          failed;
    logic [15:0] exp_n;
    logic        last_commit;

    exception_sequencer #(.DRAIN_TIMEOUT(8'd64)) dut (
        .clk             (clk),
        .rst             (rst),
        .exp_detect      (exp_detect),
        .exp_eret        (exp_eret),
        .exp_pc_address  (exp_pc_address),
        .mem_outstanding (mem_outstanding),
        .redirect_ready  (redirect_ready),
        .stall_pipe      (stall_pipe),
        .flush_pipe      (flush_pipe),
        .cp0_commit      (cp0_commit),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .drain_timeout   (drain_timeout),
        .exp_count       (exp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic d, input logic e, input logic [31:0] pc,
                         input logic m, input logic r);
        exp_detect      = d;
        exp_eret        = e;
        exp_pc_address  = pc;
        mem_outstanding = m;
        redirect_ready  = r;
        #1;
    endtask

    task automatic expect_redirect(input logic [31:0] pc, input logic commit);
        exp_item_t it;
        it.pc     = pc;
        it.commit = commit;
        sb.push_back(it);
        exp_n = exp_n + 16'd1;
    endtask

    // Observe the cycle before the edge, then advance one clock
    task automatic tick();
        exp_item_t it;
        if (flush_pipe) last_commit = cp0_commit;
        if (redirect_valid && redirect_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                failed++;
                $error("FAIL sb_unexpected: observed redirect to %h, expected none", redirect_pc);
            end
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk32("sb_pc", redirect_pc, it.pc);
                chk1("sb_commit", last_commit, it.commit);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        exp_n       = 16'd0;
        last_commit = 1'b0;
        rst         = 1'b0;
        exp_detect      = 1'b1;
        exp_eret        = 1'b0;
        exp_pc_address  = 32'h0;
        mem_outstanding = 1'b0;
        redirect_ready  = 1'b0;
        #2;
        chk1("rst_stall", stall_pipe, 1'b0);
        chk1("rst_flush", flush_pipe, 1'b0);
        chk1("rst_commit", cp0_commit, 1'b0);
        chk1("rst_valid", redirect_valid, 1'b0);
        chk32("rst_pc", redirect_pc, 32'h0);
        chk1("rst_timeout", drain_timeout, 1'b0);
        chk32("rst_count", 32'(exp_count), 32'h0);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk1("idle_stall", stall_pipe, 1'b0);
        tick();

        // Exception, no outstanding memory, fetch ready
        drive(1'b1, 1'b0, 32'hbfc00380, 1'b0, 1'b1);
        expect_redirect(32'hbfc00380, 1'b1);
        chk1("t1_stall_comb", stall_pipe, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk1("t1_flush", flush_pipe, 1'b1);
        chk1("t1_commit", cp0_commit, 1'b1);
        chk1("t1_valid_early", redirect_valid, 1'b0);
        tick();
        chk1("t1_valid", redirect_valid, 1'b1);
        chk32("t1_pc", redirect_pc, 32'hbfc00380);
        chk1("t1_flush_off", flush_pipe, 1'b0);
        tick();
        chk32("t1_count", 32'(exp_count), 32'(exp_n));
        chk1("t1_valid_off", redirect_valid, 1'b0);
        chk1("t1_stall_off", stall_pipe, 1'b0);

        // ERET, then back-to-back exception in the first IDLE cycle
        drive(1'b1, 1'b1, 32'h80001004, 1'b0, 1'b1);
        expect_redirect(32'h80001004, 1'b0);
        tick();
        chk1("t2_flush", flush_pipe, 1'b1);
        chk1("t2_commit", cp0_commit, 1'b0);
        drive(1'b1, 1'b0, 32'hdeadbeef, 1'b0, 1'b1);
        tick();
        chk1("t2_valid", redirect_valid, 1'b1);
        chk32("t2_pc", redirect_pc, 32'h80001004);
        drive(1'b1, 1'b0, 32'h00000100, 1'b0, 1'b1);
        tick();
        chk32("t2_count", 32'(exp_count), 32'(exp_n));
        chk1("t2_b2b_stall", stall_pipe, 1'b1);
        expect_redirect(32'h00000100, 1'b1);
        tick();
        chk1("t2_b2b_flush", flush_pipe, 1'b1);
        chk1("t2_b2b_commit", cp0_commit, 1'b1);
        chk32("t2_b2b_pc", redirect_pc, 32'h00000100);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        chk32("t2_b2b_count", 32'(exp_count), 32'(exp_n));

        // Drain for five cycles, memory completes on the fifth
        drive(1'b1, 1'b0, 32'h00000200, 1'b1, 1'b1);
        expect_redirect(32'h00000200, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            chk1("t3_drain_stall", stall_pipe, 1'b1);
            chk1("t3_drain_flush", flush_pipe, 1'b0);
            chk1("t3_drain_valid", redirect_valid, 1'b0);
            drive(1'b0, 1'b0, 32'h0, (i < 5), 1'b1);
            tick();
        end
        chk1("t3_flush", flush_pipe, 1'b1);
        chk1("t3_timeout", drain_timeout, 1'b0);
        tick();
        tick();
        chk32("t3_count", 32'(exp_count), 32'(exp_n));

        // Memory stuck busy: forced flush after 64 drain cycles
        drive(1'b1, 1'b0, 32'h00000240, 1'b1, 1'b1);
        expect_redirect(32'h00000240, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 1; i <= 64; i++) begin
            chk1("t4_drain_flush", flush_pipe, 1'b0);
            tick();
        end
        chk1("t4_flush", flush_pipe, 1'b1);
        chk1("t4_timeout", drain_timeout, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        chk32("t4_count", 32'(exp_count), 32'(exp_n));
        chk1("t4_timeout_sticky", drain_timeout, 1'b1);

        // Fetch stalls three cycles while a second detect is ignored
        drive(1'b1, 1'b0, 32'h00000300, 1'b0, 1'b0);
        expect_redirect(32'h00000300, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("t5_valid_hold", redirect_valid, 1'b1);
            chk32("t5_pc_hold", redirect_pc, 32'h00000300);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        chk1("t5_valid_off", redirect_valid, 1'b0);
        tick();
        chk1("t5_no_flush", flush_pipe, 1'b0);
        chk32("t5_count", 32'(exp_count), 32'(exp_n));

        // Reset mid-drain abandons the sequence
        drive(1'b1, 1'b0, 32'h00000400, 1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk1("t6_stall", stall_pipe, 1'b0);
        chk1("t6_flush", flush_pipe, 1'b0);
        chk1("t6_valid", redirect_valid, 1'b0);
        chk32("t6_pc", redirect_pc, 32'h0);
        chk1("t6_timeout", drain_timeout, 1'b0);
        chk32("t6_count", 32'(exp_count), 32'h0);
        exp_n = 16'd0;
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk1("t6_post_flush", flush_pipe, 1'b0);
            chk1("t6_post_valid", redirect_valid, 1'b0);
            tick();
        end
        chk32("t6_post_count", 32'(exp_count), 32'(exp_n));
        chk32("sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/exception_sequencer.md
EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 8'd64, maximum DRAIN-state cycles before a forced flush (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port exp_detect  input  1  exception or ERET accepted by the exception detector this cycle.
REQ-005 SHALL have port exp_eret  input  1  qualifies exp_detect as ERET (EXL clean) rather than an exception.
REQ-006 SHALL have port exp_pc_address  input  32  redirect target supplied with exp_detect.
REQ-007 SHALL have port mem_outstanding  input  1  data bus has an uncompleted transaction.
REQ-008 SHALL have port redirect_ready  input  1  fetch unit accepts the redirect.
REQ-009 SHALL have port stall_pipe  output  1  holds all pipeline stages.
REQ-010 SHALL have port flush_pipe  output  1  one-cycle kill of all in-flight instructions.
REQ-011 SHALL have port cp0_commit  output  1  one-cycle strobe to commit exception state into CP0.
REQ-012 SHALL have port redirect_valid  output  1  redirect request to fetch.
REQ-013 SHALL have port redirect_pc  output  32  redirect target.
REQ-014 SHALL have port drain_timeout  output  1  sticky flag: a drain was forced by timeout.
REQ-015 SHALL have port exp_count  output  16  saturating count of completed redirects.

Function
REQ-016 SHALL implement states IDLE, DRAIN, FLUSH, REDIRECT.
REQ-017 IDLE: on exp_detect=1, latch exp_pc_address into redirect_pc and exp_eret into an internal eret flag in the same edge; next state FLUSH if mem_outstanding=0, else DRAIN.
REQ-018 stall_pipe SHALL be combinational: 1 when (state=IDLE and exp_detect=1) or state!=IDLE; 0 otherwise.
REQ-019 DRAIN: an 8-bit counter, cleared on DRAIN entry, increments each DRAIN cycle; leave to FLUSH when mem_outstanding=0 or counter equals DRAIN_TIMEOUT-1.
REQ-020 A DRAIN exit caused solely by the timeout (mem_outstanding still 1) SHALL set drain_timeout to 1; it remains 1 until reset.
REQ-021 FLUSH: lasts exactly one cycle; flush_pipe=1; cp0_commit=1 only if the latched eret flag=0; next state REDIRECT.
REQ-022 REDIRECT: redirect_valid=1 and redirect_pc stable until the cycle with redirect_ready=1; at that edge go to IDLE and increment exp_count.
REQ-023 exp_count SHALL saturate at 16'hFFFF and not wrap.
REQ-024 exp_detect, exp_eret and exp_pc_address SHALL be ignored in every state other than IDLE; redirect_pc SHALL not change outside the IDLE capture edge.
REQ-025 redirect_ready SHALL be ignored outside REDIRECT.
REQ-026 Minimum latency with mem_outstanding=0 and redirect_ready held 1: detect edge, FLUSH cycle, REDIRECT cycle; IDLE two cycles after detect; back-to-back exp_detect in that IDLE cycle SHALL be accepted.
REQ-027 flush_pipe, cp0_commit and redirect_valid SHALL be registered-state decodes (no dependence on current-cycle inputs).

Reset
REQ-028 On rst=0, asynchronously: state IDLE, redirect_pc 32'h0, eret flag 0, drain counter 0, drain_timeout 0, exp_count 0; flush_pipe, cp0_commit, redirect_valid 0.
REQ-029 During reset, stall_pipe SHALL be 0 regardless of exp_detect.
REQ-030 Reset asserted in any state SHALL abandon the sequence; no flush, commit or redirect SHALL be emitted after reset release unless a new exp_detect arrives.

Verification
REQ-031 exp_detect=1, exp_eret=0, exp_pc_address=32'hbfc00380, mem_outstanding=0, redirect_ready=1 -> flush_pipe and cp0_commit high in cycle +1, redirect_valid with redirect_pc=32'hbfc00380 in cycle +2, exp_count=1.
REQ-032 ERET with exp_pc_address=32'h80001004 -> flush_pipe pulses, cp0_commit stays 0, redirect_pc=32'h80001004.
REQ-033 exp_detect with mem_outstanding=1 for 5 cycles then 0 -> 5 DRAIN cycles, stall_pipe held throughout, FLUSH follows, drain_timeout=0.
REQ-034 mem_outstanding stuck 1, DRAIN_TIMEOUT=64 -> FLUSH after exactly 64 DRAIN cycles, drain_timeout=1 and sticky.
REQ-035 redirect_ready=0 for 3 cycles with exp_detect pulsed to 32'h12345678 meanwhile -> redirect_valid held, redirect_pc unchanged, second request dropped.
REQ-036 rst=0 asserted during DRAIN -> all outputs at reset values immediately; after release no flush_pipe pulse, exp_count=0.
